mips32_fetch_queue: RTL and testbench

- Instruction prefetch stage directly upstream of the MIPS32 pipeline's IF/ID boundary.
- Issues word-addressed fetches (PC, PC+1, …) to instruction memory and buffers the returned words with their NPC in a small in-order queue.
- Hands instructions to decode through a valid/ready handshake.
- Accepts branch redirects from EX/MEM: flushes the queue and discards stale in-flight responses.

---
 rtl/mips32_pkg.sv | 37 +++
 rtl/mips32_fetch_fifo.sv | 81 ++++++++
 rtl/mips32_fetch_queue.sv | 162 ++++++++++++++++
 tb/tb_mips32_fetch_queue.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// -----------------------------------------------------------------------------
// mips32_pkg
// Shared definitions for the MIPS32 instruction-fetch front end:
//   - INSTR_W       : instruction word width
//   - OP_*          : primary opcode field values (instr[31:26]), including HLT
//   - fetch_state_e : fetch controller state {RUN, STOPPED}
//   - fq_entry_t    : fetch-queue entry {instr, npc}
//   - is_hlt()      : primary-opcode HLT detector
// -----------------------------------------------------------------------------
package mips32_pkg;

    localparam int INSTR_W = 32;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_HLT     = 6'b111111;

    typedef enum logic {
        RUN     = 1'b0,
        STOPPED = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        npc;
    } fq_entry_t;

    function automatic logic is_hlt(input logic [INSTR_W-1:0] instr);
        return (instr[31:26] == OP_HLT);
    endfunction

endpackage

// File: rtl/mips32_fetch_fifo.sv
// -----------------------------------------------------------------------------
// mips32_fetch_fifo
// Synchronous first-in/first-out buffer, DEPTH entries (power of two) of W bits.
// Head is read combinationally from registered storage.
// Ports:
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   push_i, wdata_i   : write request and data (accepted when not full, or
//                       when a pop happens in the same cycle)
//   pop_i, rdata_o    : remove head / head data
//   flush_i           : empty the buffer (wins over push/pop)
//   count_o           : occupancy 0..DEPTH
//   full_o, empty_o   : status
// -----------------------------------------------------------------------------
module mips32_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [W-1:0]           wdata_i,
    output logic [W-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == DEPTH_C);
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rptr_q];

    // A push into a full buffer is legal when the head leaves in the same cycle:
    // the write lands in the slot being vacated.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + PW'(1);
            if (do_pop)  rptr_d = rptr_q + PW'(1);
            cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage carries no reset; only entries counted by cnt_q are ever observed.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mips32_fetch_queue.sv
// -----------------------------------------------------------------------------
// mips32_fetch_queue
// Instruction prefetch in front of the IF/ID boundary. Issues sequential word
// fetches, buffers returned words with their next-PC in an in-order queue and
// presents the head to decode over a valid/ready handshake. Branch redirects
// flush the queue and discard every response still in flight.
//
// Optional feature (macro MIPS32_HALT_PREDECODE_EN): an enqueued HLT word
// (opcode 6'b111111) stops fetching until the next redirect; responses for
// requests issued behind the HLT are dropped. Without the macro, fetch only
// stops on halt_i and fetch_stopped is tied low.
//
// Ports:
//   clk1, rst_n                 : clock, asynchronous active-low reset
//   imem_req/addr/gnt           : fetch request channel (word address)
//   imem_rvalid/rdata           : in-order response channel
//   redirect_valid/redirect_pc  : taken-branch restart
//   halt_i                      : level, suppress new requests
//   id_valid/ready/instr/npc    : queue head towards decode
//   fetch_stopped               : no request will issue until a redirect
// -----------------------------------------------------------------------------
module mips32_fetch_queue
    import mips32_pkg::*;
#(
    parameter int            DEPTH    = 4,
    parameter int            AW       = 10,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk1,
    input  logic          rst_n,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [31:0]   imem_rdata,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    input  logic          halt_i,
    output logic          id_valid,
    input  logic          id_ready,
    output logic [31:0]   id_instr,
    output logic [31:0]   id_npc,
    output logic          fetch_stopped
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    fetch_state_e  state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [CW-1:0] drop_q, drop_d;

    logic [CW-1:0] dq_count, tq_count;
    logic          dq_full, dq_empty, tq_full, tq_empty;
    logic          dq_push, dq_pop, tq_push, tq_pop;
    fq_entry_t     dq_wdata, dq_rdata;
    logic [AW-1:0] tq_rdata;
    logic [AW-1:0] rsp_npc;
    logic [CW:0]   credit_used;
    logic          issue, rsp_keep;

    // The tag queue holds the address of every in-flight request, so its
    // occupancy is the outstanding count. Queued words plus in-flight requests
    // never exceed DEPTH, which guarantees every response has a slot.
    assign credit_used = {1'b0, dq_count} + {1'b0, tq_count};

    assign imem_req  = rst_n && (state_q == RUN) && !halt_i && !redirect_valid
                       && (credit_used < DEPTH_C);
    assign imem_addr = pc_q;
    assign issue     = imem_req & imem_gnt;

    // Every response retires its tag, including ones being discarded.
    assign tq_push  = issue & ~tq_full;
    assign tq_pop   = imem_rvalid & ~tq_empty;

    assign rsp_keep = imem_rvalid & ~redirect_valid & (drop_q == '0);
    assign rsp_npc  = tq_rdata + AW'(1);

    assign dq_wdata.instr = imem_rdata;
    assign dq_wdata.npc   = 32'(rsp_npc);
    assign dq_push        = rsp_keep & (~dq_full | dq_pop);
    assign dq_pop         = id_valid & id_ready & ~redirect_valid;

    assign id_valid = ~dq_empty;
    assign id_instr = id_valid ? dq_rdata.instr : '0;
    assign id_npc   = id_valid ? dq_rdata.npc   : '0;

`ifdef MIPS32_HALT_PREDECODE_EN
    assign fetch_stopped = (state_q == STOPPED);
`else
    assign fetch_stopped = 1'b0;
`endif

    mips32_fetch_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(fq_entry_t))
    ) u_data_q (
        .clk_i   (clk1),
        .rst_ni  (rst_n),
        .push_i  (dq_push),
        .pop_i   (dq_pop),
        .flush_i (redirect_valid),
        .wdata_i (dq_wdata),
        .rdata_o (dq_rdata),
        .count_o (dq_count),
        .full_o  (dq_full),
        .empty_o (dq_empty)
    );

    mips32_fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (AW)
    ) u_tag_q (
        .clk_i   (clk1),
        .rst_ni  (rst_n),
        .push_i  (tq_push),
        .pop_i   (tq_pop),
        .flush_i (1'b0),
        .wdata_i (pc_q),
        .rdata_o (tq_rdata),
        .count_o (tq_count),
        .full_o  (tq_full),
        .empty_o (tq_empty)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        if (redirect_valid) begin
            // Everything in flight is stale; a response arriving right now is
            // discarded here and needs no drop credit.
            pc_d    = redirect_pc;
            state_d = RUN;
            drop_d  = tq_count - CW'(imem_rvalid);
        end else begin
            if (issue) pc_d = pc_q + AW'(1);
            if (imem_rvalid && (drop_q != '0)) drop_d = drop_q - CW'(1);
`ifdef MIPS32_HALT_PREDECODE_EN
            // Requests issued behind the HLT, including one granted this cycle,
            // must not reach decode.
            if (dq_push && is_hlt(imem_rdata)) begin
                state_d = STOPPED;
                drop_d  = tq_count - CW'(1) + CW'(issue);
            end
`endif
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_mips32_fetch_queue.sv
module tb_mips32_fetch_queue;

    logic        clk1 = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [9:0]  redirect_pc = 10'h0;
    logic        halt_i = 1'b0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_npc;
    logic        fetch_stopped;

    int n_cmp = 0;
    int n_err = 0;
    int lat = 1;
    int n_gnt = 0;
    int cyc = 0;
    int hlt_addr = -1;
    int unsigned pend_addr[$];
    int pend_due[$];

    always #5 clk1 = ~clk1;

    mips32_fetch_queue dut (
        .clk1           (clk1),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_i         (halt_i),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_npc         (id_npc),
        .fetch_stopped  (fetch_stopped)
    );

    function automatic logic [31:0] mem_word(input int unsigned a);
        if (int'(a) == hlt_addr) return 32'hFC00_0000;
        return 32'h1000_0000 + 32'(a);
    endfunction

    // Instruction memory: in-order responses, 'lat' cycles after the grant.
    always @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            pend_addr.delete();
            pend_due.delete();
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
            n_gnt = 0;
        end else begin
            cyc++;
            if (imem_rvalid) begin
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
            if (imem_req && imem_gnt) begin
                pend_addr.push_back(int'(imem_addr));
                pend_due.push_back(cyc + lat - 1);
                n_gnt++;
            end
            #1;
            if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr[0]);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int l, input logic g, input logic r);
        @(negedge clk1);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        halt_i = 1'b0;
        lat = l;
        imem_gnt = g;
        id_ready = r;
        @(negedge clk1);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;

        // Reset values, then a 1-cycle memory with decode always ready
        imem_gnt = 1'b1;
        id_ready = 1'b1;
        lat = 1;
        #2 rst_n = 1'b0;
        @(negedge clk1);
        chk("rst_req", imem_req, 0);
        chk("rst_valid", id_valid, 0);
        chk("rst_instr", id_instr, 0);
        chk("rst_npc", id_npc, 0);
        chk("rst_stopped", fetch_stopped, 0);
        rst_n = 1'b1;
        @(negedge clk1);
        chk("t1_novalid_yet", id_valid, 0);
        chk("t1_req", imem_req, 1);
        chk("t1_addr", imem_addr, 1);
        @(negedge clk1);
        chk("t1_valid", id_valid, 1);
        chk("t1_instr0", id_instr, 32'h1000_0000);
        chk("t1_npc0", id_npc, 1);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk1);
            chk($sformatf("t1_instr%0d", i), id_instr, 32'h1000_0000 + 32'(i));
            chk($sformatf("t1_npc%0d", i), id_npc, 32'(i + 1));
        end

        // Decode stalled: credits cap requests at DEPTH
        do_reset(1, 1'b1, 1'b0);
        repeat (6) @(negedge clk1);
        chk("t2_grants", n_gnt, 4);
        chk("t2_req_off", imem_req, 0);
        chk("t2_valid", id_valid, 1);
        chk("t2_head", id_instr, 32'h1000_0000);
        chk("t2_npc", id_npc, 1);
        id_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk1);
            chk($sformatf("t2_resume%0d", i), id_instr, 32'h1000_0000 + 32'(i));
        end

        // Redirect with two requests in flight, 3-cycle memory
        do_reset(3, 1'b1, 1'b1);
        repeat (2) @(negedge clk1);
        chk("t3_inflight", n_gnt, 2);
        imem_gnt = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 10'h020;
        #1;
        chk("t3_req_redir", imem_req, 0);
        chk("t3_empty", id_valid, 0);
        @(negedge clk1);
        redirect_valid = 1'b0;
        imem_gnt = 1'b1;
        #1;
        chk("t3_req_after", imem_req, 1);
        chk("t3_addr_after", imem_addr, 10'h020);
        for (int i = 0; i < 20 && !id_valid; i++) @(negedge clk1);
        chk("t3_valid", id_valid, 1);
        chk("t3_instr", id_instr, 32'h1000_0020);
        chk("t3_npc", id_npc, 32'h21);

        // Redirect coinciding with a response and a dequeue
        do_reset(1, 1'b1, 1'b0);
        repeat (2) @(negedge clk1);
        chk("t4_head_valid", id_valid, 1);
        chk("t4_head", id_instr, 32'h1000_0000);
        redirect_valid = 1'b1;
        redirect_pc = 10'h040;
        id_ready = 1'b1;
        #1;
        chk("t4_req_redir", imem_req, 0);
        @(negedge clk1);
        chk("t4_flushed", id_valid, 0);
        redirect_valid = 1'b0;
        #1;
        chk("t4_req", imem_req, 1);
        chk("t4_addr", imem_addr, 10'h040);
        @(negedge clk1);
        chk("t4_no_stale", id_valid, 0);
        @(negedge clk1);
        chk("t4_valid", id_valid, 1);
        chk("t4_instr", id_instr, 32'h1000_0040);
        chk("t4_npc", id_npc, 32'h41);

        // PC wrap at the top of the address space
        do_reset(1, 1'b1, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc = 10'h3FF;
        #1;
        chk("t5_req_redir", imem_req, 0);
        @(negedge clk1);
        redirect_valid = 1'b0;
        #1;
        chk("t5_req", imem_req, 1);
        chk("t5_addr_top", imem_addr, 10'h3FF);
        @(negedge clk1);
        chk("t5_addr_wrap", imem_addr, 10'h000);
        @(negedge clk1);
        chk("t5_valid", id_valid, 1);
        chk("t5_instr_top", id_instr, 32'h1000_03FF);
        chk("t5_npc_top", id_npc, 0);
        @(negedge clk1);
        chk("t5_instr_0", id_instr, 32'h1000_0000);
        chk("t5_npc_0", id_npc, 1);

        // Redirect while halted: pc moves, no fetch until halt falls
        halt_i = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 10'h100;
        #1;
        chk("t6_req_redir", imem_req, 0);
        @(negedge clk1);
        redirect_valid = 1'b0;
        #1;
        chk("t6_req_halt", imem_req, 0);
        chk("t6_addr", imem_addr, 10'h100);
        chk("t6_flushed", id_valid, 0);
        @(negedge clk1);
        chk("t6_req_halt2", imem_req, 0);
        chk("t6_empty2", id_valid, 0);
        halt_i = 1'b0;
        #1;
        chk("t6_req_resume", imem_req, 1);
        for (int i = 0; i < 20 && !id_valid; i++) @(negedge clk1);
        chk("t6_valid", id_valid, 1);
        chk("t6_instr", id_instr, 32'h1000_0100);
        chk("t6_npc", id_npc, 32'h101);

`ifdef MIPS32_HALT_PREDECODE_EN
        // HLT at word 5 stops fetch after delivering it
        hlt_addr = 5;
        do_reset(1, 1'b1, 1'b1);
        idx = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk1);
            if (id_valid) begin
                chk($sformatf("hlt_instr%0d", idx), id_instr,
                    (idx == 5) ? 32'hFC00_0000 : 32'h1000_0000 + 32'(idx));
                chk($sformatf("hlt_npc%0d", idx), id_npc, 32'(idx + 1));
                idx++;
            end
        end
        chk("hlt_delivered", idx, 6);
        chk("hlt_stopped", fetch_stopped, 1);
        chk("hlt_req_off", imem_req, 0);
        chk("hlt_grants", n_gnt, 7);
        redirect_valid = 1'b1;
        redirect_pc = 10'h000;
        #1;
        chk("hlt_req_redir", imem_req, 0);
        @(negedge clk1);
        redirect_valid = 1'b0;
        #1;
        chk("hlt_restart_stopped", fetch_stopped, 0);
        chk("hlt_restart_req", imem_req, 1);
        chk("hlt_restart_addr", imem_addr, 10'h000);
`else
        idx = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
